// File: rtl/fpu_share_controller.sv
// -----------------------------------------------------------------------------
// fpu_share_controller
//
// Purpose:
//   Shares one fixed-point arithmetic unit (add/sub/mul/sqrt) between two
//   requesters. One operation is in flight at a time; contention is resolved
//   round-robin. The unit is held in reset whenever it is not running an
//   operation, so its sticky ready flag is cleared before every new operation.
//   Results return over a valid/ready response channel, tagged with the
//   requester id. An operation that never completes is aborted after TIMEOUT
//   RUN cycles and answered with rsp_timeout=1 and a zero result.
//
// Parameters:
//   WIDTH    operand/result width (must match the arithmetic unit)
//   TIMEOUT  maximum RUN cycles before abort (8..1023)
//
// Ports:
//   clk                          clock, all state on the rising edge
//   reset                        asynchronous active-high reset
//   req0_valid / req1_valid      requester has an operation pending
//   req0_operation / req1_operation  2-bit op code
//   req0_operand_1/_2, req1_operand_1/_2  operands
//   req0_ready / req1_ready      accept strobe (combinational, IDLE only)
//   rsp_valid / rsp_ready        response handshake
//   rsp_id                       requester id of the response
//   rsp_result                   unit result (0 on timeout)
//   rsp_timeout                  operation was aborted
//   fpu_reset                    registered reset to the unit
//   fpu_operation                registered op code to the unit
//   fpu_operand_1/_2             registered operands to the unit
//   fpu_result / fpu_ready       unit result and completion
// -----------------------------------------------------------------------------
module fpu_share_controller #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [1:0]       req0_operation,
  input  logic [WIDTH-1:0] req0_operand_1,
  input  logic [WIDTH-1:0] req0_operand_2,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [1:0]       req1_operation,
  input  logic [WIDTH-1:0] req1_operand_1,
  input  logic [WIDTH-1:0] req1_operand_2,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_timeout,
  output logic             fpu_reset,
  output logic [1:0]       fpu_operation,
  output logic [WIDTH-1:0] fpu_operand_1,
  output logic [WIDTH-1:0] fpu_operand_2,
  input  logic [WIDTH-1:0] fpu_result,
  input  logic             fpu_ready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  // Counter value seen in the last permitted RUN cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic             fpu_reset_q, fpu_reset_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd1_q, opnd1_d;
  logic [WIDTH-1:0] opnd2_q, opnd2_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             timeout_q, timeout_d;

  logic             gnt_any;
  logic             gnt_id;
  logic             accept;

  // ---------------------------------------------------------------------------
  // Round-robin grant. With both requesters valid the one that was not served
  // last wins; last_grant starts at 1 so req0 wins the first contention.
  // ---------------------------------------------------------------------------
  always_comb begin
    gnt_any    = req0_valid | req1_valid;
    gnt_id     = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    req0_ready = (state_q == S_IDLE) && !reset && gnt_any && !gnt_id;
    req1_ready = (state_q == S_IDLE) && !reset && gnt_any &&  gnt_id;
    accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  end

  // ---------------------------------------------------------------------------
  // Sequencer next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    op_d         = op_q;
    opnd1_d      = opnd1_q;
    opnd2_d      = opnd2_q;
    cnt_d        = cnt_q;
    result_d     = result_q;
    timeout_d    = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          id_d         = gnt_id;
          last_grant_d = gnt_id;
          op_d         = gnt_id ? req1_operation : req0_operation;
          opnd1_d      = gnt_id ? req1_operand_1 : req0_operand_1;
          opnd2_d      = gnt_id ? req1_operand_2 : req0_operand_2;
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        // Unit is still in reset with operands stable, so it captures them.
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Completion wins over timeout when both happen in the same cycle.
        if (fpu_ready) begin
          result_d  = fpu_result;
          timeout_d = 1'b0;
          state_d   = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          result_d  = '0;
          timeout_d = 1'b1;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Unit runs only while the next state is RUN; held in reset otherwise.
    fpu_reset_d = (state_d != S_RUN);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      fpu_reset_q  <= 1'b1;
      op_q         <= '0;
      opnd1_q      <= '0;
      opnd2_q      <= '0;
      cnt_q        <= '0;
      result_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      fpu_reset_q  <= fpu_reset_d;
      op_q         <= op_d;
      opnd1_q      <= opnd1_d;
      opnd2_q      <= opnd2_d;
      cnt_q        <= cnt_d;
      result_q     <= result_d;
      timeout_q    <= timeout_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_id        = id_q;
  assign rsp_result    = result_q;
  assign rsp_timeout   = timeout_q;
  assign fpu_reset     = fpu_reset_q;
  assign fpu_operation = op_q;
  assign fpu_operand_1 = opnd1_q;
  assign fpu_operand_2 = opnd2_q;

endmodule

// File: tb/tb_fpu_share_controller.sv
module tb_fpu_share_controller;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 8;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL  = 2'd2;
  localparam logic [1:0] OP_SQRT = 2'd3;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [1:0]       req0_operation, req1_operation;
  logic [WIDTH-1:0] req0_operand_1, req0_operand_2;
  logic [WIDTH-1:0] req1_operand_1, req1_operand_2;
  logic             req0_ready, req1_ready;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_timeout;
  logic [WIDTH-1:0] rsp_result;
  logic             fpu_reset;
  logic [1:0]       fpu_operation;
  logic [WIDTH-1:0] fpu_operand_1, fpu_operand_2;
  logic [WIDTH-1:0] fpu_result;
  logic             fpu_ready;

  int n_checks = 0;
  int n_fail   = 0;

  fpu_share_controller #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_operation(req0_operation),
    .req0_operand_1(req0_operand_1), .req0_operand_2(req0_operand_2),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_operation(req1_operation),
    .req1_operand_1(req1_operand_1), .req1_operand_2(req1_operand_2),
    .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout),
    .fpu_reset(fpu_reset), .fpu_operation(fpu_operation),
    .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
    .fpu_result(fpu_result), .fpu_ready(fpu_ready)
  );

  always #5 clk = ~clk;

  // Arithmetic unit stub: FBITS=10 fixed point, ready after a per-op number of
  // cycles out of reset (ADD/SUB 0, MUL 2, SQRT 3). stub_stall never completes.
  logic              stub_stall = 1'b0;
  int                run_cnt = 0;
  logic signed [63:0] prod;
  int                lat;

  always @(posedge clk) begin
    if (fpu_reset) run_cnt <= 0;
    else           run_cnt <= run_cnt + 1;
  end

  always_comb begin
    prod       = $signed({{32{fpu_operand_1[31]}}, fpu_operand_1}) *
                 $signed({{32{fpu_operand_2[31]}}, fpu_operand_2});
    fpu_result = 32'hDEADBEEF;
    lat        = 3;
    case (fpu_operation)
      OP_ADD:  begin fpu_result = fpu_operand_1 + fpu_operand_2; lat = 0; end
      OP_SUB:  begin fpu_result = fpu_operand_1 - fpu_operand_2; lat = 0; end
      OP_MUL:  begin fpu_result = prod[41:10]; lat = 2; end
      default: begin fpu_result = 32'hDEADBEEF; lat = 3; end
    endcase
    fpu_ready = !fpu_reset && !stub_stall && (run_cnt >= lat);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int max, output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_operation = OP_ADD; req1_operation = OP_ADD;
    req0_operand_1 = '0; req0_operand_2 = '0;
    req1_operand_1 = '0; req1_operand_2 = '0;
    rsp_ready = 1'b0;
    step(); step();
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_timeout, fpu_reset, req0_ready, req1_ready} !== 6'b000100) begin
      n_fail++;
      $display("FAIL reset_ctrl: got v=%b id=%b to=%b frst=%b r0=%b r1=%b, want 0 0 0 1 0 0",
               rsp_valid, rsp_id, rsp_timeout, fpu_reset, req0_ready, req1_ready);
    end
    n_checks++;
    if (rsp_result !== 32'h0 || fpu_operation !== 2'd0 || fpu_operand_1 !== 32'h0 || fpu_operand_2 !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_data: got res=%h op=%0d o1=%h o2=%h, want all 0",
               rsp_result, fpu_operation, fpu_operand_1, fpu_operand_2);
    end
    reset = 1'b0;
    #1;
    // First contention after reset goes to req0.
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL first_contention: got r1r0=%b, want 01", {req1_ready, req0_ready});
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_add();
    int n;
    req0_operation = OP_ADD; req0_operand_1 = 32'h00000C00; req0_operand_2 = 32'h00000400;
    req0_valid = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL add_ready: got r1r0=%b, want 01", {req1_ready, req0_ready});
    end
    step();
    req0_valid = 1'b0;
    n_checks++;
    if (fpu_reset !== 1'b1 || fpu_operation !== OP_ADD || fpu_operand_1 !== 32'h00000C00 || fpu_operand_2 !== 32'h00000400) begin
      n_fail++;
      $display("FAIL add_load: got frst=%b op=%0d o1=%h o2=%h, want 1 0 00000c00 00000400",
               fpu_reset, fpu_operation, fpu_operand_1, fpu_operand_2);
    end
    wait_rsp(10, n);
    n_checks++;
    if (rsp_valid !== 1'b1 || n != 2 || rsp_id !== 1'b0 || rsp_result !== 32'h00001000 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL add_rsp: got v=%b edges=%0d id=%b res=%h to=%b, want 1 2 0 00001000 0",
               rsp_valid, n, rsp_id, rsp_result, rsp_timeout);
    end
    handshake();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_rsp_drop: got rsp_valid=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_mul();
    int n;
    req1_operation = OP_MUL; req1_operand_1 = 32'h00000C00; req1_operand_2 = 32'h00000800;
    req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({req1_ready, req0_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL mul_ready: got r1r0=%b, want 10", {req1_ready, req0_ready});
    end
    step();
    req1_valid = 1'b0;
    n_checks++;
    if (fpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_load_reset: got fpu_reset=%b, want 1", fpu_reset);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (fpu_reset !== 1'b0 || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_run_%0d: got fpu_reset=%b rsp_valid=%b, want 0 0", i, fpu_reset, rsp_valid);
      end
    end
    wait_rsp(10, n);
    n_checks++;
    if (rsp_valid !== 1'b1 || n != 1 || rsp_id !== 1'b1 || rsp_result !== 32'h00001800 || rsp_timeout !== 1'b0 || fpu_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL mul_rsp: got v=%b extra=%0d id=%b res=%h to=%b frst=%b, want 1 1 1 00001800 0 1",
               rsp_valid, n, rsp_id, rsp_result, rsp_timeout, fpu_reset);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int n;
    logic exp_id;
    logic [WIDTH-1:0] exp_res;
    req0_operation = OP_SUB; req0_operand_1 = 32'h00002000; req0_operand_2 = 32'h00000800;
    req1_operation = OP_SUB; req1_operand_1 = 32'h00001000; req1_operand_2 = 32'h00001400;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id  = k[0];
      exp_res = exp_id ? 32'hFFFFFC00 : 32'h00001800;
      n_checks++;
      if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL rr_grant_%0d: got r1r0=%b, want id %0d", k, {req1_ready, req0_ready}, exp_id);
      end
      step();
      wait_rsp(10, n);
      n_checks++;
      if (rsp_valid !== 1'b1 || n != 2 || rsp_id !== exp_id || rsp_result !== exp_res) begin
        n_fail++;
        $display("FAIL rr_rsp_%0d: got v=%b edges=%0d id=%b res=%h, want 1 2 %0d %h",
                 k, rsp_valid, n, rsp_id, rsp_result, exp_id, exp_res);
      end
      n_checks++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
        n_fail++;
        $display("FAIL rr_resp_block_%0d: got r1r0=%b, want 00", k, {req1_ready, req0_ready});
      end
      handshake();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    int n;
    req0_operation = OP_ADD; req0_operand_1 = 32'h00000100; req0_operand_2 = 32'h00000200;
    req1_operation = OP_ADD; req1_operand_1 = 32'h00000001; req1_operand_2 = 32'h00000001;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    wait_rsp(10, n);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_result !== 32'h00000300 || req1_ready !== 1'b0 || req0_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b id=%b res=%h r1=%b r0=%b, want 1 0 00000300 0 0",
                 i, rsp_valid, rsp_id, rsp_result, req1_ready, req0_ready);
      end
      step();
    end
    handshake();
    n_checks++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b r1=%b, want 0 1", rsp_valid, req1_ready);
    end
    step();
    req1_valid = 1'b0;
    wait_rsp(10, n);
    n_checks++;
    if (rsp_valid !== 1'b1 || n != 2 || rsp_id !== 1'b1 || rsp_result !== 32'h00000002) begin
      n_fail++;
      $display("FAIL bp_next: got v=%b edges=%0d id=%b res=%h, want 1 2 1 00000002",
               rsp_valid, n, rsp_id, rsp_result);
    end
    handshake();
  endtask

  task automatic test_timeout();
    int n;
    stub_stall = 1'b1;
    req0_operation = OP_SQRT; req0_operand_1 = 32'h00001000; req0_operand_2 = 32'h0;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    wait_rsp(30, n);
    n_checks++;
    if (rsp_valid !== 1'b1 || n != TIMEOUT + 1 || rsp_timeout !== 1'b1 || rsp_result !== 32'h0 || rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_rsp: got v=%b edges=%0d to=%b res=%h id=%b, want 1 %0d 1 00000000 0",
               rsp_valid, n, rsp_timeout, rsp_result, rsp_id, TIMEOUT + 1);
    end
    handshake();
    stub_stall = 1'b0;
    req1_operation = OP_ADD; req1_operand_1 = 32'h00000005; req1_operand_2 = 32'h00000006;
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    wait_rsp(10, n);
    n_checks++;
    if (rsp_valid !== 1'b1 || n != 2 || rsp_timeout !== 1'b0 || rsp_result !== 32'h0000000B || rsp_id !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_next: got v=%b edges=%0d to=%b res=%h id=%b, want 1 2 0 0000000b 1",
               rsp_valid, n, rsp_timeout, rsp_result, rsp_id);
    end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int n;
    req1_operation = OP_MUL; req1_operand_1 = 32'h00000C00; req1_operand_2 = 32'h00000800;
    req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    step();
    n_checks++;
    if (fpu_reset !== 1'b0 || fpu_operation !== OP_MUL) begin
      n_fail++;
      $display("FAIL midrun_setup: got frst=%b op=%0d, want 0 2", fpu_reset, fpu_operation);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({rsp_valid, rsp_id, rsp_timeout, fpu_reset, req0_ready, req1_ready} !== 6'b000100 ||
        rsp_result !== 32'h0 || fpu_operation !== 2'd0 || fpu_operand_1 !== 32'h0 || fpu_operand_2 !== 32'h0) begin
      n_fail++;
      $display("FAIL midrun_async: got v=%b id=%b to=%b frst=%b r0=%b r1=%b res=%h op=%0d o1=%h o2=%h, want reset values",
               rsp_valid, rsp_id, rsp_timeout, fpu_reset, req0_ready, req1_ready,
               rsp_result, fpu_operation, fpu_operand_1, fpu_operand_2);
    end
    step(); step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrun_no_rsp_%0d: got rsp_valid=%b, want 0", i, rsp_valid);
      end
    end
    req0_operation = OP_ADD; req0_operand_1 = 32'h00000010; req0_operand_2 = 32'h00000020;
    req0_valid = 1'b1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_ready: got req0_ready=%b, want 1", req0_ready);
    end
    step();
    req0_valid = 1'b0;
    wait_rsp(10, n);
    n_checks++;
    if (rsp_valid !== 1'b1 || n != 2 || rsp_id !== 1'b0 || rsp_result !== 32'h00000030 || rsp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_next: got v=%b edges=%0d id=%b res=%h to=%b, want 1 2 0 00000030 0",
               rsp_valid, n, rsp_id, rsp_result, rsp_timeout);
    end
    handshake();
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
